nios_vjtag_scan_master: RTL and testbench
=========================================

// Module: nios_vjtag_scan_master
// PURPOSE
//  Parallel-command initiator for the Nios II virtual-JTAG debug port. Drives the vji_* signal set
//  (tck/tdi/ir_in/uir/cdr/sdr/udr/rti) into the debug module's TCK-side logic and captures vji_tdo.
//  Each command is one IR-select plus one DR scan. Used for on-chip self-test and debug bring-up
//  without an external USB-Blaster. Sits in the system clock domain; generates tck from clk.
// PARAMETERS
//  DR_W     38  data-register scan length in bits (matches jdo/sr width)
//  IR_W     2   virtual IR width
//  TCK_DIV  2   clk cycles per tck half-period (>=1); tck period = 2*TCK_DIV clk
// PORTS
//  clk          in   1     system clock
//  reset_n      in   1     asynchronous active-low reset
//  cmd_valid    in   1     command request
//  cmd_ready    out  1     command accepted when cmd_valid & cmd_ready
//  cmd_ir       in   IR_W  virtual IR code (0 OCIMEM, 1 TRACEMEM, 2 BREAK, 3 TRACECTRL)
//  cmd_data     in   DR_W  DR shift-in data, LSB shifted first
//  rsp_valid    out  1     response available; held until rsp_ready
//  rsp_ready    in   1     response consumed
//  rsp_data     out  DR_W  captured tdo bits; first captured bit in bit 0
//  rsp_ir_out   out  IR_W  vji_ir_out sampled in CDR
//  vji_tck      out  1     generated test clock
//  vji_tdi      out  1     serial data to debug module
//  vji_tdo      in   1     serial data from debug module
//  vji_ir_in    out  IR_W  current virtual IR value
//  vji_ir_out   in   IR_W  IR status from debug module
//  vji_uir/cdr/sdr/udr out 1 each  virtual state indicators
//  vji_rti      out  1     run-test-idle indicator
// BEHAVIOUR
//  - Async reset: state IDLE, all outputs 0 (incl. cmd_ready, vji_ir_in, rsp_*); cmd_ready rises the
//    first clk after reset_n deasserts. All outputs registered.
//  - FSM: IDLE -> UIR -> CDR -> SDR -> UDR -> RESP -> IDLE. cmd_ready=1 only in IDLE; command
//    latched on accept; tck starts the next clk.
//  - tck held 0 in IDLE/RESP; toggles every TCK_DIV clk otherwise. rise/fall strobes mark the clk
//    where tck goes 0->1 / 1->0. State, tdi, and vji_* indicators change only on fall strobes.
//  - UIR: 1 tck period; vji_ir_in <= cmd_ir; vji_uir=1. CDR: 1 period; vji_cdr=1; rsp_ir_out
//    sampled on rise.
//  - SDR: exactly DR_W periods; vji_sdr=1; vji_tdi=shreg[0]; on each rise shreg <=
//    {vji_tdo, shreg[DR_W-1:1]}. UDR: 1 period; vji_udr=1.
//  - RESP: rsp_data=shreg; rsp_valid=1 until rsp_ready (same-cycle handshake). Next command
//    accepted no earlier than the clk after rsp handshake.
//  - vji_rti=1 in IDLE and RESP, else 0. At most one of uir/cdr/sdr/udr is high at any time.
//  - Latency: accept at cycle 0 -> rsp_valid at cycle (DR_W+3)*2*TCK_DIV+1.
//    Default: 41*4+1 = 165.
//  - Bit counter is $clog2(DR_W+1) wide; SDR exits on the fall after the DR_W-th rise. No
//    wrap-around.
//  - cmd_valid ignored outside IDLE; cmd_* must stay stable only in the accept cycle.
//  - Reset mid-scan: immediate abort, no UDR issued, response discarded.
// CONFIGURATION
//  NIOS_VJTAG_IR_SKIP_EN defined:
//    - Last IR value is remembered (invalid after reset).
//    - If cmd_ir equals the last IR, UIR is skipped (IDLE -> CDR).
//    - Latency becomes (DR_W+2)*2*TCK_DIV+1.
//  Not defined: UIR is always issued; no IR memory logic.
// STRUCTURE
//  Package nios_vjtag_pkg holds:
//    - state enum {IDLE,UIR,CDR,SDR,UDR,RESP}
//    - IR code constants IR_OCIMEM/IR_TRACEMEM/IR_BREAK/IR_TRACECTRL
//    - DR_W_DEFAULT=38
//  Sub-module nios_vjtag_tck_gen (TCK_DIV counter, run input; outputs tck, rise, fall).
//  FSM, shift register and bit counter live in the top.
// TESTING
//  1. Reset check: hold reset_n=0 -> all outputs 0; release -> cmd_ready=1 the next clk,
//     vji_rti=1, tck static.
//  2. Loopback scan: vji_tdo tied to a 1-tck-delayed vji_tdi model; cmd_ir=2'b00,
//     cmd_data=38'h2A_5555_AAAA.
//     -> uir/cdr/sdr/udr each seen once in order; exactly 38 tck rises in SDR;
//        rsp_valid at cycle 165; rsp_data as the loopback model predicts.
//  3. Constant tdo=1, cmd_ir=2'b10 -> rsp_data=38'h3F_FFFF_FFFF; vji_ir_in=2'b10 from UIR onward;
//     vji_ir_out=2'b01 -> rsp_ir_out=2'b01.
//  4. Backpressure: rsp_ready=0 for 10 clk in RESP -> rsp_valid/rsp_data stable, cmd_ready=0,
//     tck static; new cmd_valid not accepted until the clk after handshake.
//  5. Reset at 17th SDR bit -> all outputs 0 asynchronously, no udr pulse; next command after
//     release completes normally.
//  6. NIOS_VJTAG_IR_SKIP_EN: two commands with cmd_ir=2'b01 -> uir on the first only; second
//     latency 161 clk. Then cmd_ir=2'b11 -> uir issued.

Source files
------------

// File: rtl/nios_vjtag_pkg.sv
// Shared types and constants for the Nios II virtual-JTAG scan master.
// Build option NIOS_VJTAG_IR_SKIP_EN (see nios_vjtag_scan_master) does not affect this file.
package nios_vjtag_pkg;

  localparam int DR_W_DEFAULT = 38;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RESP} state_t;

  // Indicator pattern {udr, sdr, cdr, uir} driven while in a given state.
  function automatic logic [3:0] ind_of(state_t s);
    case (s)
      UIR:     return 4'b0001;
      CDR:     return 4'b0010;
      SDR:     return 4'b0100;
      UDR:     return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/nios_vjtag_scan_master_if.sv
// Command/response handshake bundle between a requester and the scan master.
interface nios_vjtag_scan_master_if #(
  parameter int DR_W = nios_vjtag_pkg::DR_W_DEFAULT,
  parameter int IR_W = 2
) ();

  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [DR_W-1:0] cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DR_W-1:0] rsp_data;
  logic [IR_W-1:0] rsp_ir_out;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );

endinterface

// File: rtl/nios_vjtag_tck_gen.sv
// Test-clock generator: tck toggles every TCK_DIV clk while run is high, with
// registered one-clk rise/fall strobes aligned to the cycle tck changes.
module nios_vjtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TCK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tck  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      tck  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tck  <= ~tck;
      rise <= ~tck;
      fall <= tck;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

endmodule

// File: rtl/nios_vjtag_scan_master.sv
// Parallel-command initiator for the Nios II virtual-JTAG debug port: one IR select plus one DR scan per command.
// Define NIOS_VJTAG_IR_SKIP_EN to skip the UIR phase when the IR code matches the previous command.
module nios_vjtag_scan_master
  import nios_vjtag_pkg::*;
#(
  parameter int DR_W    = DR_W_DEFAULT,
  parameter int IR_W    = 2,
  parameter int TCK_DIV = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  nios_vjtag_scan_master_if.slave   bus,
  output logic                      vji_tck,
  output logic                      vji_tdi,
  input  logic                      vji_tdo,
  output logic [IR_W-1:0]           vji_ir_in,
  input  logic [IR_W-1:0]           vji_ir_out,
  output logic                      vji_uir,
  output logic                      vji_cdr,
  output logic                      vji_sdr,
  output logic                      vji_udr,
  output logic                      vji_rti
);

  localparam int CNT_W = $clog2(DR_W + 1);

  state_t           state;
  logic [3:0]       ind;
  logic [DR_W-1:0]  shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             run, rise, fall;
`ifdef NIOS_VJTAG_IR_SKIP_EN
  logic             ir_known;
`endif

  assign run = (state != IDLE) && (state != RESP);
  assign {vji_udr, vji_sdr, vji_cdr, vji_uir} = ind;

  nios_vjtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .tck     (vji_tck),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ind            <= '0;
      shreg          <= '0;
      bit_cnt        <= '0;
      vji_tdi        <= 1'b0;
      vji_ir_in      <= '0;
      vji_rti        <= 1'b0;
      bus.cmd_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_ir_out <= '0;
`ifdef NIOS_VJTAG_IR_SKIP_EN
      ir_known       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_ready && bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            vji_rti       <= 1'b0;
            shreg         <= bus.cmd_data;
            vji_ir_in     <= bus.cmd_ir;
`ifdef NIOS_VJTAG_IR_SKIP_EN
            ir_known      <= 1'b1;
            if (ir_known && (bus.cmd_ir == vji_ir_in)) begin
              state <= CDR;
              ind   <= ind_of(CDR);
            end else begin
              state <= UIR;
              ind   <= ind_of(UIR);
            end
`else
            state         <= UIR;
            ind           <= ind_of(UIR);
`endif
          end else begin
            bus.cmd_ready <= 1'b1;
            vji_rti       <= 1'b1;
          end
        end
        UIR: begin
          if (fall) begin
            state <= CDR;
            ind   <= ind_of(CDR);
          end
        end
        CDR: begin
          if (rise) bus.rsp_ir_out <= vji_ir_out;
          if (fall) begin
            state   <= SDR;
            ind     <= ind_of(SDR);
            vji_tdi <= shreg[0];
            bit_cnt <= '0;
          end
        end
        SDR: begin
          if (rise) begin
            shreg   <= {vji_tdo, shreg[DR_W-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
          // tdi only advances on falls so the debug module sees it stable across each rise.
          if (fall) begin
            if (bit_cnt == CNT_W'(DR_W)) begin
              state   <= UDR;
              ind     <= ind_of(UDR);
              vji_tdi <= 1'b0;
            end else begin
              vji_tdi <= shreg[0];
            end
          end
        end
        UDR: begin
          if (fall) begin
            state         <= RESP;
            ind           <= ind_of(RESP);
            vji_rti       <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= shreg;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ind   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_vjtag_scan_master.sv
// Self-checking bench for nios_vjtag_scan_master: directed and randomized scans against a
// scan-level reference model; expectations follow NIOS_VJTAG_IR_SKIP_EN when it is defined.
module tb_nios_vjtag_scan_master;

  localparam int DR_W    = 38;
  localparam int IR_W    = 2;
  localparam int TCK_DIV = 2;
  localparam logic [63:0] MASK = (64'd1 << DR_W) - 64'd1;
  localparam int LAT_FULL = (DR_W + 3) * 2 * TCK_DIV + 1;
  localparam int LAT_SKIP = (DR_W + 2) * 2 * TCK_DIV + 1;
`ifdef NIOS_VJTAG_IR_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic            clk, reset_n;
  logic            vji_tck, vji_tdi, vji_tdo;
  logic [IR_W-1:0] vji_ir_in, vji_ir_out;
  logic            vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  nios_vjtag_scan_master_if #(.DR_W(DR_W), .IR_W(IR_W)) bus ();

  nios_vjtag_scan_master #(.DR_W(DR_W), .IR_W(IR_W), .TCK_DIV(TCK_DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .vji_tck    (vji_tck),
    .vji_tdi    (vji_tdi),
    .vji_tdo    (vji_tdo),
    .vji_ir_in  (vji_ir_in),
    .vji_ir_out (vji_ir_out),
    .vji_uir    (vji_uir),
    .vji_cdr    (vji_cdr),
    .vji_sdr    (vji_sdr),
    .vji_udr    (vji_udr),
    .vji_rti    (vji_rti)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int sdr_rises = 0;
  int viol = 0;
  int acc_cyc, hs_cyc;
  logic [15:0] seq = '0;
  logic [3:0]  prev_ind = '0;
  bit          udr_seen = 1'b0;
  bit          exp_skip;
  bit          ir_known = 1'b0;
  logic [1:0]  last_ir = '0;
  bit          tdo_const = 1'b0;
  logic        loop_bit = 1'b0;
  bit          preload = 1'b0;
  logic [1:0]  next_ir;
  logic [DR_W-1:0] next_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Debug-module stand-in: tdo returns the tdi bit of the previous tck period.
  always @(negedge vji_tck) loop_bit = vji_tdi;
  assign vji_tdo = tdo_const ? 1'b1 : loop_bit;

  always @(posedge vji_tck) if (vji_sdr) sdr_rises++;

  always @(negedge clk) begin
    logic [3:0] ind;
    ind = {vji_udr, vji_sdr, vji_cdr, vji_uir};
    if ($countones(ind) > 1) viol++;
    if (vji_rti && vji_tck) viol++;
    if (ind != prev_ind && ind != 4'd0) seq = {seq[11:0], ind};
    if (vji_udr) udr_seen = 1'b1;
    prev_ind = ind;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cmd_ready"},  64'(bus.cmd_ready), 64'd0);
    check({tag, "_rsp_valid"},  64'(bus.rsp_valid), 64'd0);
    check({tag, "_rsp_data"},   64'(bus.rsp_data), 64'd0);
    check({tag, "_rsp_ir_out"}, 64'(bus.rsp_ir_out), 64'd0);
    check({tag, "_tck"},        64'(vji_tck), 64'd0);
    check({tag, "_tdi"},        64'(vji_tdi), 64'd0);
    check({tag, "_ir_in"},      64'(vji_ir_in), 64'd0);
    check({tag, "_ind"},        64'({vji_udr, vji_sdr, vji_cdr, vji_uir}), 64'd0);
    check({tag, "_rti"},        64'(vji_rti), 64'd0);
  endtask

  // Present a command at a negedge and wait for its accept edge.
  task automatic start_cmd(input logic [1:0] ir, input logic [DR_W-1:0] data);
    int n;
    sdr_rises = 0;
    seq = '0;
    udr_seen = 1'b0;
    viol = 0;
    bus.cmd_ir = ir;
    bus.cmd_data = data;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(bus.cmd_ready), 64'd1);
    acc_cyc = cyc + 1;
    exp_skip = SKIP_EN && ir_known && (ir == last_ir);
    ir_known = 1'b1;
    last_ir = ir;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_ir = ~ir;
    bus.cmd_data = ~data;
    check("ir_in_after_accept", 64'(vji_ir_in), 64'(ir));
  endtask

  task automatic finish_cmd(input int hold, input logic [63:0] exp_data, input logic [1:0] exp_irout);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait", 64'(bus.rsp_valid), 64'd1);
    check("latency", 64'(cyc - acc_cyc), exp_skip ? 64'(LAT_SKIP) : 64'(LAT_FULL));
    check("rsp_data", 64'(bus.rsp_data), exp_data);
    check("rsp_ir_out", 64'(bus.rsp_ir_out), 64'(exp_irout));
    check("sdr_rises", 64'(sdr_rises), 64'(DR_W));
    check("state_order", 64'(seq), exp_skip ? 64'h0248 : 64'h1248);
    check("indicator_rules", 64'(viol), 64'd0);
    check("rti_in_resp", 64'(vji_rti), 64'd1);
    if (preload) begin
      bus.cmd_ir = next_ir;
      bus.cmd_data = next_data;
      bus.cmd_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_rsp_data", 64'(bus.rsp_data), exp_data);
      check("hold_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      check("hold_tck", 64'(vji_tck), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    hs_cyc = cyc;
    bus.rsp_ready = 1'b0;
    check("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
    check("ready_after_hs", 64'(bus.cmd_ready), 64'd1);
  endtask

  task automatic do_cmd(input logic [1:0] ir, input logic [DR_W-1:0] data, input bit tconst,
                        input logic [1:0] irout, input int hold);
    vji_ir_out = irout;
    tdo_const = tconst;
    start_cmd(ir, data);
    finish_cmd(hold, tconst ? MASK : (({26'd0, data} << 1) & MASK), irout);
  endtask

  initial begin
    int n;
    logic [DR_W-1:0] d;
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_ir = '0;
    bus.cmd_data = '0;
    bus.rsp_ready = 1'b0;
    vji_ir_out = '0;

    // Reset state and release.
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    #1;
    check("ready_before_clk", 64'(bus.cmd_ready), 64'd0);
    @(negedge clk);
    check("ready_after_release", 64'(bus.cmd_ready), 64'd1);
    check("rti_after_release", 64'(vji_rti), 64'd1);
    repeat (3) @(negedge clk);
    check("idle_tck_static", 64'(vji_tck), 64'd0);

    // Loopback scan, then constant-one tdo with a BREAK IR.
    do_cmd(2'b00, 38'h2A_5555_AAAA, 1'b0, 2'b11, 0);
    do_cmd(2'b10, 38'h12_3456_789A, 1'b1, 2'b01, 0);
    check("ir_in_held", 64'(vji_ir_in), 64'd2);

    // Backpressure with the next command already waiting.
    preload = 1'b1;
    next_ir = 2'b11;
    next_data = 38'h15_0F0F_3C3C;
    vji_ir_out = 2'b10;
    tdo_const = 1'b0;
    start_cmd(2'b01, 38'h0A_CAFE_F00D);
    finish_cmd(10, ({26'd0, 38'h0A_CAFE_F00D} << 1) & MASK, 2'b10);
    preload = 1'b0;
    start_cmd(next_ir, next_data);
    check("accept_after_hs", 64'(acc_cyc), 64'(hs_cyc + 1));
    finish_cmd(0, ({26'd0, next_data} << 1) & MASK, 2'b10);

    // Randomized scans.
    for (int i = 0; i < 4; i++) begin
      d = DR_W'({$urandom(), $urandom()});
      do_cmd(2'($urandom_range(3)), d, 1'b0, 2'($urandom_range(3)), int'($urandom_range(3)));
    end

    // Asynchronous reset during the 17th SDR bit.
    vji_ir_out = 2'b11;
    start_cmd(2'b11, DR_W'({$urandom(), $urandom()}));
    n = 0;
    while (sdr_rises < 17 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit17", 64'(sdr_rises), 64'd17);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("midscan_reset");
    ir_known = 1'b0;
    repeat (4) @(negedge clk);
    check("no_udr_on_abort", 64'(udr_seen), 64'd0);
    reset_n = 1'b1;

    // Repeated IR then a new IR; UIR is dropped only on the repeat when skipping is built in.
    do_cmd(2'b01, 38'h3F_0000_FFFF, 1'b0, 2'b00, 1);
    do_cmd(2'b01, 38'h00_FFFF_0001, 1'b0, 2'b01, 0);
    do_cmd(2'b11, 38'h25_A5A5_5A5A, 1'b0, 2'b10, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
